control_sequencer: RTL
======================

# control_sequencer

Hard-wired control unit for the Phase 2 datapath. Runs the fetch/decode/execute T-state sequence and drives every datapath control strobe, one T-state per clock. It decodes the opcode held in the datapath IR and replaces bench-driven control of `Datapath`. It sits beside `Datapath` and connects to it strobe-for-strobe.

## Interface
- `OPW`, 5: opcode width, taken from `ir[31:27]`.
- `clk`  in  1: system clock, all state changes on rising edge.
- `clr`  in  1: synchronous reset, active high. Sampled on `clk` rising edge.
- `run`  in  1: permission to start the next instruction fetch.
- `ir`  in  32: datapath IR contents. Opcode is `ir[31:27]`.
- `pc_out`, `zlo_out`, `mdr_out`, `mar_enable`, `z_enable`, `pc_enable`, `mdr_enable`, `read`, `ir_enable`, `y_enable`, `pc_increment`, `c_sign_extended_out`, `ram_write`, `r_in`, `r_out`, `gra`, `grb`, `grc`, `ba_out`  out  1 each: datapath strobes, same meaning as the `Datapath` ports of the same name.
- `alu_op`  out  4: ALU function code. 0000 ADD, 0001 SUB, 0010 AND, 0011 OR.
- `instr_done`  out  1: high during the last T-state of each instruction.
- `illegal`  out  1: high during T3 when the opcode is undefined.
- `halted`  out  1: high while in HALT.

## Operation
- States: IDLE, T0–T7, HALT. Registered state; all outputs decode from the state and `ir[31:27]` (Moore-style per opcode). Any strobe not listed for a state is 0. `alu_op` defaults to ADD.
- Opcodes:
  - ld 00000, ldi 00001, st 00010.
  - add 00011, sub 00100, and 00101, or 00110.
  - addi 01100, andi 01101, ori 01110.
  - nop 11010, halt 11011.
  - All others are undefined.
- IDLE: all outputs 0. Go to T0 when `run`=1.
- Fetch:
  - T0: `pc_out`, `mar_enable`, `pc_increment`, `z_enable`.
  - T1: `zlo_out`, `pc_enable`, `read`, `mdr_enable`.
  - T2: `mdr_out`, `ir_enable`.
- `ir` is read only in T3–T7. The IR is not rewritten until the next T2, so no internal opcode latch is needed.
- ldi: T3 `grb` `ba_out` `y_enable`; T4 `c_sign_extended_out` `z_enable` ADD; T5 `zlo_out` `gra` `r_in`, done.
- addi/andi/ori: as ldi, but T3 uses `r_out` instead of `ba_out`, and T4 uses `alu_op` ADD/AND/OR respectively.
- add/sub/and/or: T3 `grb` `r_out` `y_enable`; T4 `grc` `r_out` `z_enable` with `alu_op`; T5 `zlo_out` `gra` `r_in`, done.
- ld: T3–T4 as ldi; T5 `zlo_out` `mar_enable`; T6 `read` `mdr_enable`; T7 `mdr_out` `gra` `r_in`, done.
- st: T3–T5 as ld; T6 `gra` `r_out` `mdr_enable` with `read`=0 (MDR loads from bus); T7 `ram_write`, done.
- nop and undefined opcodes: T3 asserts no strobes, done. An undefined opcode also asserts `illegal`.
- halt: T3 asserts no strobes, done, then HALT. HALT is held until `clr`; `run` is ignored.
- After a done state: go to T0 if `run`=1, else IDLE.

## Timing
- `clr`=1 at an edge: state becomes IDLE at that edge. This overrides every other transition, including mid-instruction; an in-flight instruction is abandoned with no further strobes.
- While in IDLE, all outputs are 0, including `halted`.
- Instruction lengths from T0: ldi, I-type and R-type take 6 cycles; ld and st take 8; nop, halt and undefined take 4.
- With `run` held at 1, back-to-back instructions have zero gap: T0 follows the done state directly.
- `run` is sampled only in IDLE and in done states. Dropping `run` mid-instruction has no effect until done.
- `ram_write` and `read` are never high in the same cycle. `r_in` is never high together with `r_out`.

## Test plan
- Reset: hold `clr`=1 for 2 cycles with `run`=1 → all outputs 0 and `halted`=0. Release → T0 strobes appear on the second edge after release (IDLE→T0).
- ldi: `ir`=0x0900_0013 (ldi R2,R0,0x13) with `run`=1 → T0..T5 strobes exactly as listed, `instr_done` in cycle 6. Against `Datapath`, R2 = 0x13.
- andi: R2=0x13, `ir`=0x6910_000F → T4 `alu_op`=0010, and R2 = 0x03 after T5.
- st then ld: store R2 = 0x3 to address 0x90, then load it into R3 → `ram_write` is high exactly in cycle 8 of st, and R3 = 0x3 after T7 of ld.
- halt, illegal, run: opcode 11011 → `halted`=1 from the 5th edge, held for 20 cycles with `run`=1. Opcode 11111 → `illegal` high in T3 only. `run`=0 at done → IDLE until `run` rises.
- Mid-instruction reset: assert `clr` in T6 of st → `ram_write` never asserts and the state is IDLE on the next edge.

Source files
------------

// File: rtl/control_sequencer.sv
//------------------------------------------------------------------------------
// control_sequencer : hard-wired fetch/decode/execute control unit that
//                     drives every datapath strobe, one T-state per clock.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module control_sequencer #(
   parameter int OPW = 5
) (
   input  logic        clk,
   input  logic        clr,
   input  logic        run,
   input  logic [31:0] ir,
   output logic        pc_out,
   output logic        zlo_out,
   output logic        mdr_out,
   output logic        mar_enable,
   output logic        z_enable,
   output logic        pc_enable,
   output logic        mdr_enable,
   output logic        read,
   output logic        ir_enable,
   output logic        y_enable,
   output logic        pc_increment,
   output logic        c_sign_extended_out,
   output logic        ram_write,
   output logic        r_in,
   output logic        r_out,
   output logic        gra,
   output logic        grb,
   output logic        grc,
   output logic        ba_out,
   output logic [3:0]  alu_op,
   output logic        instr_done,
   output logic        illegal,
   output logic        halted
);

   typedef enum logic [3:0] {
      S_IDLE = 4'd0, S_T0 = 4'd1, S_T1 = 4'd2, S_T2 = 4'd3, S_T3 = 4'd4,
      S_T4   = 4'd5, S_T5 = 4'd6, S_T6 = 4'd7, S_T7 = 4'd8, S_HALT = 4'd9
   } state_t;

   localparam logic [3:0] c_ALU_ADD = 4'b0000;
   localparam logic [3:0] c_ALU_SUB = 4'b0001;
   localparam logic [3:0] c_ALU_AND = 4'b0010;
   localparam logic [3:0] c_ALU_OR  = 4'b0011;

   state_t state_q;

   logic [OPW-1:0] w_op;
   logic           w_unused_ir;
   logic w_ld, w_st, w_ldi, w_imm, w_reg, w_nop, w_halt, w_undef, w_done;

   // The IR is stable from T3 until the next T2, so decode straight from it.
   assign w_op        = ir[31 -: OPW];
   assign w_unused_ir = ^ir[31-OPW:0];

   assign w_ld    = (w_op == OPW'(5'b00000));
   assign w_ldi   = (w_op == OPW'(5'b00001));
   assign w_st    = (w_op == OPW'(5'b00010));
   assign w_reg   = (w_op == OPW'(5'b00011)) || (w_op == OPW'(5'b00100)) ||
                    (w_op == OPW'(5'b00101)) || (w_op == OPW'(5'b00110));
   assign w_imm   = (w_op == OPW'(5'b01100)) || (w_op == OPW'(5'b01101)) ||
                    (w_op == OPW'(5'b01110));
   assign w_nop   = (w_op == OPW'(5'b11010));
   assign w_halt  = (w_op == OPW'(5'b11011));
   assign w_undef = !(w_ld || w_ldi || w_st || w_reg || w_imm || w_nop || w_halt);

   assign w_done = ((state_q == S_T3) && (w_nop || w_halt || w_undef)) ||
                   ((state_q == S_T5) && (w_ldi || w_imm || w_reg)) ||
                   ((state_q == S_T7) && (w_ld || w_st));

   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: if (run) state_q <= S_T0;
            S_T0:   state_q <= S_T1;
            S_T1:   state_q <= S_T2;
            S_T2:   state_q <= S_T3;
            S_HALT: state_q <= S_HALT;
            default: begin
               if (w_done) begin
                  if (w_halt)   state_q <= S_HALT;
                  else if (run) state_q <= S_T0;
                  else          state_q <= S_IDLE;
               end else begin
                  case (state_q)
                     S_T3:    state_q <= S_T4;
                     S_T4:    state_q <= S_T5;
                     S_T5:    state_q <= S_T6;
                     S_T6:    state_q <= S_T7;
                     default: state_q <= S_IDLE;
                  endcase
               end
            end
         endcase
      end
   end

   always_comb begin
      pc_out = 1'b0; zlo_out = 1'b0; mdr_out = 1'b0; mar_enable = 1'b0;
      z_enable = 1'b0; pc_enable = 1'b0; mdr_enable = 1'b0; read = 1'b0;
      ir_enable = 1'b0; y_enable = 1'b0; pc_increment = 1'b0;
      c_sign_extended_out = 1'b0; ram_write = 1'b0; r_in = 1'b0; r_out = 1'b0;
      gra = 1'b0; grb = 1'b0; grc = 1'b0; ba_out = 1'b0;
      alu_op = c_ALU_ADD;
      instr_done = w_done;
      illegal = 1'b0;
      halted = (state_q == S_HALT);
      case (state_q)
         S_T0: begin
            pc_out = 1'b1; mar_enable = 1'b1; pc_increment = 1'b1; z_enable = 1'b1;
         end
         S_T1: begin
            zlo_out = 1'b1; pc_enable = 1'b1; read = 1'b1; mdr_enable = 1'b1;
         end
         S_T2: begin
            mdr_out = 1'b1; ir_enable = 1'b1;
         end
         S_T3: begin
            if (w_ld || w_st || w_ldi || w_imm || w_reg) begin
               grb      = 1'b1;
               y_enable = 1'b1;
               ba_out   = w_ld || w_st || w_ldi;
               r_out    = w_imm || w_reg;
            end
            illegal = w_undef;
         end
         S_T4: begin
            z_enable            = 1'b1;
            grc                 = w_reg;
            r_out               = w_reg;
            c_sign_extended_out = !w_reg;
            case (w_op)
               OPW'(5'b00100):                 alu_op = c_ALU_SUB;
               OPW'(5'b00101), OPW'(5'b01101): alu_op = c_ALU_AND;
               OPW'(5'b00110), OPW'(5'b01110): alu_op = c_ALU_OR;
               default:                        alu_op = c_ALU_ADD;
            endcase
         end
         S_T5: begin
            zlo_out    = 1'b1;
            mar_enable = w_ld || w_st;
            gra        = !(w_ld || w_st);
            r_in       = !(w_ld || w_st);
         end
         S_T6: begin
            mdr_enable = 1'b1;
            read       = w_ld;
            gra        = w_st;
            r_out      = w_st;
         end
         S_T7: begin
            mdr_out   = w_ld;
            gra       = w_ld;
            r_in      = w_ld;
            ram_write = w_st;
         end
         default: ;
      endcase
   end

endmodule

`default_nettype wire
